// File: rtl/vga_digit_glyph.sv
// Seven-segment decimal digit overlay for a VGA raster, two-stage registered pixel flag.
// Optional blinking is compiled in by defining DIGIT_BLINK_EN.
module vga_digit_glyph #(
    parameter int START_X      = 85,
    parameter int START_Y      = 150,
    parameter int SEG_W        = 20,
    parameter int SEG_H        = 40,
    parameter int THICK        = 1,
    parameter int BLINK_PERIOD = 32
) (
    input  logic        CLK_VGA,
    input  logic        RST_N,
    input  logic [11:0] VGA_horzCoord,
    input  logic [11:0] VGA_vertCoord,
    input  logic [3:0]  DIGIT,
    input  logic        DIGIT_VALID,
    input  logic        BLINK,
    output logic        OUTPUT
);

    localparam logic [11:0] X0  = 12'(START_X);
    localparam logic [11:0] X0T = 12'(START_X + THICK);
    localparam logic [11:0] XR  = 12'(START_X + SEG_W);
    localparam logic [11:0] XRT = 12'(START_X + SEG_W + THICK);
    localparam logic [11:0] Y0  = 12'(START_Y);
    localparam logic [11:0] Y0T = 12'(START_Y + THICK);
    localparam logic [11:0] YM  = 12'(START_Y + SEG_H / 2);
    localparam logic [11:0] YMT = 12'(START_Y + SEG_H / 2 + THICK);
    localparam logic [11:0] YB  = 12'(START_Y + SEG_H);
    localparam logic [11:0] YBT = 12'(START_Y + SEG_H + THICK);

    // Segment order is {a,b,c,d,e,f,g}, MSB = a.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] segs;
        case (d)
            4'd0:    segs = 7'b1111110;
            4'd1:    segs = 7'b0110000;
            4'd2:    segs = 7'b1101101;
            4'd3:    segs = 7'b1111001;
            4'd4:    segs = 7'b0110011;
            4'd5:    segs = 7'b1011011;
            4'd6:    segs = 7'b1011111;
            4'd7:    segs = 7'b1110000;
            4'd8:    segs = 7'b1111111;
            4'd9:    segs = 7'b1111011;
            default: segs = 7'b0000000;
        endcase
        return segs;
    endfunction

    logic       frame_start;
    logic [3:0] pend;
    logic [3:0] active;
    logic       pend_flag;

    assign frame_start = (VGA_horzCoord == 12'd0) && (VGA_vertCoord == 12'd0);

    // NOTE: state registers use non-blocking assignments so every register samples
    // pre-edge values; blocking here would make ordering between blocks matter.
    always_ff @(posedge CLK_VGA or negedge RST_N) begin
        if (!RST_N) begin
            pend      <= 4'hF;
            pend_flag <= 1'b0;
            active    <= 4'hF;
        end else begin
            if (DIGIT_VALID)
                pend <= DIGIT;
            if (frame_start) begin
                // A strobe coinciding with frame start bypasses the pending slot.
                if (DIGIT_VALID)
                    active <= DIGIT;
                else if (pend_flag)
                    active <= pend;
                pend_flag <= 1'b0;
            end else if (DIGIT_VALID) begin
                pend_flag <= 1'b1;
            end
        end
    end

    logic       h_mid, col_l, col_r, rows_up, rows_lo;
    logic [6:0] hit_d;
    logic [6:0] hit_q;
    logic       blank_d;
    logic       blank_q;

    assign h_mid   = (VGA_horzCoord > X0) && (VGA_horzCoord < XR);
    assign col_l   = (VGA_horzCoord >= X0) && (VGA_horzCoord < X0T);
    assign col_r   = (VGA_horzCoord >= XR) && (VGA_horzCoord < XRT);
    assign rows_up = (VGA_vertCoord > Y0) && (VGA_vertCoord < YM);
    assign rows_lo = (VGA_vertCoord > YM) && (VGA_vertCoord < YB);

    assign hit_d[6] = h_mid && (VGA_vertCoord >= Y0) && (VGA_vertCoord < Y0T);
    assign hit_d[5] = col_r && rows_up;
    assign hit_d[4] = col_r && rows_lo;
    assign hit_d[3] = h_mid && (VGA_vertCoord >= YB) && (VGA_vertCoord < YBT);
    assign hit_d[2] = col_l && rows_lo;
    assign hit_d[1] = col_l && rows_up;
    assign hit_d[0] = h_mid && (VGA_vertCoord >= YM) && (VGA_vertCoord < YMT);

`ifdef DIGIT_BLINK_EN
    localparam int             CW       = (BLINK_PERIOD > 2) ? $clog2(BLINK_PERIOD) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(BLINK_PERIOD - 1);
    localparam logic [CW-1:0]  CNT_HALF = CW'(BLINK_PERIOD / 2);

    logic [CW-1:0] frame_cnt;

    always_ff @(posedge CLK_VGA or negedge RST_N) begin
        if (!RST_N)
            frame_cnt <= '0;
        else if (frame_start)
            frame_cnt <= (frame_cnt == CNT_LAST) ? '0 : frame_cnt + 1'b1;
    end

    assign blank_d = BLINK && (frame_cnt >= CNT_HALF);
`else
    logic unused_cfg;
    assign unused_cfg = BLINK ^ 1'(BLINK_PERIOD % 2);
    assign blank_d    = 1'b0;
`endif

    // Stage 1: region hits and blink gate; stage 2: decode against the active digit.
    always_ff @(posedge CLK_VGA or negedge RST_N) begin
        if (!RST_N) begin
            hit_q   <= '0;
            blank_q <= 1'b0;
            OUTPUT  <= 1'b0;
        end else begin
            hit_q   <= hit_d;
            blank_q <= blank_d;
            OUTPUT  <= (|(hit_q & seg_decode(active))) && !blank_q;
        end
    end

endmodule

// File: tb/tb_vga_digit_glyph.sv
// Directed bench for vga_digit_glyph: a geometric reference model checked every cycle,
// plus literal pixel expectations. Two instances: THICK=1/period 32 and THICK=3/period 4.
module tb_vga_digit_glyph;

    logic        clk;
    logic        rst_n;
    logic [11:0] h;
    logic [11:0] v;
    logic [3:0]  digit;
    logic        dv;
    logic        blink;
    logic        out_a;
    logic        out_b;

    int n_checks = 0;
    int n_err    = 0;

    vga_digit_glyph dut_a (
        .CLK_VGA(clk), .RST_N(rst_n), .VGA_horzCoord(h), .VGA_vertCoord(v),
        .DIGIT(digit), .DIGIT_VALID(dv), .BLINK(blink), .OUTPUT(out_a)
    );

    vga_digit_glyph #(.THICK(3), .BLINK_PERIOD(4)) dut_b (
        .CLK_VGA(clk), .RST_N(rst_n), .VGA_horzCoord(h), .VGA_vertCoord(v),
        .DIGIT(digit), .DIGIT_VALID(dv), .BLINK(blink), .OUTPUT(out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int X0 = 85, XR = 105, Y0 = 150, YM = 170, YB = 190;
    int THK [2] = '{1, 3};
    int PER [2] = '{32, 4};

    logic [6:0] seg_tab [0:9] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                  7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                  7'b1111111, 7'b1111011};

    function automatic logic pix_on(input int x, input int y, input int d, input int t);
        logic hm, lc, rc, up, lo;
        logic [6:0] segs;
        if (d > 9) return 1'b0;
        hm = (x > X0) && (x < XR);
        lc = (x >= X0) && (x < X0 + t);
        rc = (x >= XR) && (x < XR + t);
        up = (y > Y0) && (y < YM);
        lo = (y > YM) && (y < YB);
        segs = {hm && y >= Y0 && y < Y0 + t, rc && up, rc && lo,
                hm && y >= YB && y < YB + t, lc && lo, lc && up,
                hm && y >= YM && y < YM + t};
        return |(segs & seg_tab[d]);
    endfunction

    int   m_active [2];
    int   m_pend   [2];
    bit   m_flag   [2];
    int   m_cnt    [2];
    logic m_stage  [2];
    logic m_exp    [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_active[k] = 15; m_pend[k] = 15; m_flag[k] = 0; m_cnt[k] = 0;
                m_stage[k] = 1'b0; m_exp[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                bit fs;
                bit gate;
                fs   = (h == 0) && (v == 0);
                gate = 0;
`ifdef DIGIT_BLINK_EN
                gate = blink && (m_cnt[k] >= PER[k] / 2);
`endif
                if (fs && dv) begin
                    m_active[k] = int'(digit); m_pend[k] = int'(digit); m_flag[k] = 0;
                end else begin
                    if (dv) begin m_pend[k] = int'(digit); m_flag[k] = 1; end
                    if (fs && m_flag[k]) begin m_active[k] = m_pend[k]; m_flag[k] = 0; end
                end
                if (fs) m_cnt[k] = (m_cnt[k] + 1) % PER[k];
                m_exp[k]   = m_stage[k];
                m_stage[k] = pix_on(int'(h), int'(v), m_active[k], THK[k]) && !gate;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("model_a", out_a, m_exp[0]);
            check("model_b", out_b, m_exp[1]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_xy(input int x, input int y);
        @(negedge clk);
        h = 12'(x);
        v = 12'(y);
    endtask

    task automatic pix(input int x, input int y, input bit sel_b, input logic exp, input string name);
        set_xy(x, y);
        repeat (2) @(negedge clk);
        check(name, sel_b ? out_b : out_a, exp);
    endtask

    task automatic strobe(input int d);
        @(negedge clk);
        digit = 4'(d);
        dv    = 1'b1;
        @(negedge clk);
        dv    = 1'b0;
    endtask

    task automatic frame();
        set_xy(0, 0);
        set_xy(1, 1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [7:0] blink_pat;

    initial begin
        rst_n = 1'b0; h = 12'd1; v = 12'd1; digit = 4'd0; dv = 1'b0; blink = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_out_a", out_a, 1'b0);
        check("reset_out_b", out_b, 1'b0);
        rst_n = 1'b1;

        // digit 3 segment probes
        strobe(3);
        frame();
        pix(86, 150, 0, 1'b1, "d3_a_seg");
        pix(105, 151, 0, 1'b1, "d3_b_seg");
        pix(86, 170, 0, 1'b1, "d3_g_seg");
        pix(86, 190, 0, 1'b1, "d3_d_seg");
        pix(85, 150, 0, 1'b0, "d3_corner_tl");
        pix(85, 160, 0, 1'b0, "d3_f_off");
        pix(105, 150, 0, 1'b0, "d3_corner_tr");

        // mid-frame strobe takes effect only at next frame start
        strobe(8);
        pix(85, 160, 0, 1'b0, "d8_held_back");
        frame();
        pix(85, 160, 0, 1'b1, "d8_after_frame");

        // strobe coincident with frame start
        @(negedge clk);
        h = 12'd0; v = 12'd0; digit = 4'd1; dv = 1'b1;
        @(negedge clk);
        dv = 1'b0; h = 12'd1; v = 12'd1;
        pix(90, 150, 0, 1'b0, "d1_top_off");
        pix(105, 160, 0, 1'b1, "d1_right_on");

        // out-of-range digit blanks everything
        strobe(12);
        frame();
        pix(90, 150, 0, 1'b0, "d12_a");
        pix(85, 160, 0, 1'b0, "d12_f");
        pix(90, 170, 1, 1'b0, "d12_g_thick");
        pix(105, 180, 0, 1'b0, "d12_c");
        pix(90, 190, 1, 1'b0, "d12_d_thick");

        // stroke thickness
        strobe(8);
        frame();
        pix(90, 152, 1, 1'b1, "thick3_row2");
        pix(90, 153, 1, 1'b0, "thick3_row3");
        pix(90, 152, 0, 1'b0, "thick1_row2");

        // asynchronous reset mid-scan
        pix(90, 150, 0, 1'b1, "pre_reset_on");
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_a", out_a, 1'b0);
        check("async_reset_b", out_b, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        frame();
        pix(90, 150, 0, 1'b0, "blank_after_reset");
        strobe(8);
        pix(90, 150, 0, 1'b0, "blank_until_frame");
        frame();
        pix(90, 150, 0, 1'b1, "drawn_after_frame");

        // blinking: frame counter is 1 after the first frame start following reset
        pulse_reset();
        blink = 1'b1;
        strobe(8);
        frame();
`ifdef DIGIT_BLINK_EN
        blink_pat = 8'b1001_1001;
`else
        blink_pat = 8'b1111_1111;
`endif
        for (int f = 0; f < 8; f++) begin
            pix(90, 150, 1, blink_pat[7 - f], $sformatf("blink_on_frame%0d", f));
            frame();
        end
        blink = 1'b0;
        for (int f = 0; f < 4; f++) begin
            pix(90, 150, 1, 1'b1, $sformatf("noblink_frame%0d", f));
            frame();
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
